// File: rtl/my9262_pkg.sv
// Shared types and sizing helpers for the MY9262 frame sequencer.
package my9262_pkg;

    localparam int CH_PER_CHIP = 16;
    localparam int GS_BITS     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    function automatic int word_count(input int chips);
        return chips * CH_PER_CHIP;
    endfunction

endpackage

// File: rtl/my9262_clk_div.sv
// Half-period down-counter: toggles tog_o and pulses phase_end_o every DIV enabled cycles.
module my9262_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tog_o,
    output logic phase_end_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC_LOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tog_q, tog_d;

    always_comb begin
        phase_end_o = en && !clr && (cnt_q == '0);
        cnt_d       = cnt_q;
        tog_d       = tog_q;
        if (clr) begin
            cnt_d = TC_LOAD;
            tog_d = 1'b0;
        end else if (phase_end_o) begin
            cnt_d = TC_LOAD;
            tog_d = ~tog_q;
        end else if (en) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= TC_LOAD;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

    assign tog_o = tog_q;

endmodule

// File: rtl/my9262_frame_ctrl.sv
// Frame sequencer: fetches grayscale words, shifts them MSB-first to a MY9262 chain, latches, runs Gck.
//   state    | meaning
//   ST_IDLE  | waiting for frame_start
//   ST_FETCH | issue rd_en for the current word index
//   ST_LOAD  | capture rd_data into the shift register
//   ST_SHIFT | clock 16 bits out on Di/Dclk
//   ST_LATCH | Lat high for LAT_CLKS cycles
//   ST_DONE  | one-cycle frame_done
module my9262_frame_ctrl
    import my9262_pkg::*;
#(
    parameter int CHIPS    = 4,
    parameter int DCLK_DIV = 4,
    parameter int GCK_DIV  = 2,
    parameter int LAT_CLKS = 4,
    parameter int ADDR_W   = 6
) (
    input  logic              CLK_200M,
    input  logic              RST,
    input  logic              frame_start,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              my9262_Lat,
    output logic              my9262_Dclk,
    output logic              my9262_Gck,
    output logic              my9262_Di
);

    localparam int W  = word_count(CHIPS);
    localparam int BW = $clog2(GS_BITS);
    localparam int LW = (LAT_CLKS > 1) ? $clog2(LAT_CLKS) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(W - 1);
    localparam logic [BW-1:0]     LAST_BIT = BW'(GS_BITS - 1);
    localparam logic [LW-1:0]     LAT_TC   = LW'(LAT_CLKS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GS_BITS-1:0]  shift_q, shift_d;
    logic [LW-1:0]       lat_cnt_q, lat_cnt_d;

    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                di_q, di_d;
    logic                lat_q, lat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                dclk_tog;
    logic                dclk_phase_end;
    logic                gck_tog;
    logic                gck_phase_end_unused;
    logic                in_shift;

    assign in_shift = (state_q == ST_SHIFT);

    // Dclk phase timer only runs while shifting; it sits at low phase otherwise.
    my9262_clk_div #(.DIV(DCLK_DIV)) u_dclk_div (
        .clk         (CLK_200M),
        .rst         (RST),
        .en          (in_shift),
        .clr         (!in_shift),
        .tog_o       (dclk_tog),
        .phase_end_o (dclk_phase_end)
    );

    my9262_clk_div #(.DIV(GCK_DIV)) u_gck_div (
        .clk         (CLK_200M),
        .rst         (RST),
        .en          (1'b1),
        .clr         (1'b0),
        .tog_o       (gck_tog),
        .phase_end_o (gck_phase_end_unused)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        lat_cnt_d  = lat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_FETCH;
                    word_idx_d = LAST_IDX;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = rd_data;
                bit_cnt_d = LAST_BIT;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                // A bit completes at the end of the Dclk high phase.
                if (dclk_phase_end && dclk_tog) begin
                    shift_d   = {shift_q[GS_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == '0) begin
                        if (word_idx_q == '0) begin
                            state_d   = ST_LATCH;
                            lat_cnt_d = LAT_TC;
                        end else begin
                            word_idx_d = word_idx_q - ADDR_W'(1);
                            state_d    = ST_FETCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end
            ST_DONE: begin
                // A held frame_start chains straight into the next frame.
                word_idx_d = LAST_IDX;
                state_d    = frame_start ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_en_d   = (state_d == ST_FETCH);
        rd_addr_d = (state_d == ST_FETCH) ? word_idx_d : '0;
        di_d      = (state_d == ST_SHIFT) ? shift_d[GS_BITS-1] : 1'b0;
        lat_d     = (state_d == ST_LATCH);
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_200M) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            word_idx_q <= LAST_IDX;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            lat_cnt_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            di_q       <= 1'b0;
            lat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            di_q       <= di_d;
            lat_q      <= lat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign frame_busy  = busy_q;
    assign frame_done  = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign my9262_Lat  = lat_q;
    assign my9262_Dclk = dclk_tog;
    assign my9262_Gck  = gck_tog;
    assign my9262_Di   = di_q;

endmodule

// File: tb/tb_my9262_frame_ctrl.sv
// Directed bench for my9262_frame_ctrl: one small-chain instance and one 4-chip instance.
module tb_my9262_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: CHIPS=1, DCLK_DIV=2, GCK_DIV=2, LAT_CLKS=4
    logic        rst_a = 1'b1, fs_a = 1'b0;
    logic        busy_a, done_a, rden_a, lat_a, dclk_a, gck_a, di_a;
    logic [5:0]  addr_a;
    logic [15:0] rdata_a = 16'h0;

    // Instance B: CHIPS=4, DCLK_DIV=1, GCK_DIV=2, LAT_CLKS=4
    logic        rst_b = 1'b1, fs_b = 1'b0;
    logic        busy_b, done_b, rden_b, lat_b, dclk_b, gck_b, di_b;
    logic [5:0]  addr_b;
    logic [15:0] rdata_b;
    assign rdata_b = 16'hFFFF;

    my9262_frame_ctrl #(.CHIPS(1), .DCLK_DIV(2), .GCK_DIV(2), .LAT_CLKS(4), .ADDR_W(6)) dut_a (
        .CLK_200M(clk), .RST(rst_a), .frame_start(fs_a), .frame_busy(busy_a),
        .frame_done(done_a), .rd_en(rden_a), .rd_addr(addr_a), .rd_data(rdata_a),
        .my9262_Lat(lat_a), .my9262_Dclk(dclk_a), .my9262_Gck(gck_a), .my9262_Di(di_a)
    );

    my9262_frame_ctrl #(.CHIPS(4), .DCLK_DIV(1), .GCK_DIV(2), .LAT_CLKS(4), .ADDR_W(6)) dut_b (
        .CLK_200M(clk), .RST(rst_b), .frame_start(fs_b), .frame_busy(busy_b),
        .frame_done(done_b), .rd_en(rden_b), .rd_addr(addr_b), .rd_data(rdata_b),
        .my9262_Lat(lat_b), .my9262_Dclk(dclk_b), .my9262_Gck(gck_b), .my9262_Di(di_b)
    );

    // Frame memory for A: word[i] = A000+i, one-cycle read latency.
    always @(posedge clk) begin
        if (rden_a) rdata_a <= 16'hA000 + {10'd0, addr_a};
    end

    // Gck on A must repeat every 4 samples and invert every 2.
    logic       gck_mon = 1'b0;
    logic [3:0] gh = 4'd0;
    int         gv = 0;
    int         gck_err = 0;
    always @(negedge clk) begin
        if (gck_mon) begin
            if (gv >= 4 && (gck_a !== gh[3] || gck_a === gh[1])) gck_err++;
            gh = {gh[2:0], gck_a};
            if (gv < 4) gv++;
        end else begin
            gv = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on A from IDLE; optional extra frame_start pulse at cycle inject_at.
    task automatic run_frame_a(input string tag, input int inject_at);
        int rises, lat_cyc, lat_first, lat_pulses, done_cyc, done_cnt, n_rd, exp_addr, r;
        logic prev_dclk, prev_lat;
        logic [15:0] w;
        rises = 0; lat_cyc = 0; lat_first = 0; lat_pulses = 0;
        done_cyc = 0; done_cnt = 0; n_rd = 0; exp_addr = 15;
        prev_dclk = 1'b0; prev_lat = 1'b0;
        @(negedge clk) fs_a = 1'b1;
        @(posedge clk);
        #1 fs_a = 1'b0;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (n == 1) chk({tag, "_busy_c1"}, {31'd0, busy_a}, 32'd1);
            if (inject_at != 0 && n == inject_at) fs_a = 1'b1;
            if (inject_at != 0 && n == inject_at + 1) fs_a = 1'b0;
            if (rden_a) begin
                chk({tag, "_rd_addr"}, {26'd0, addr_a}, exp_addr);
                exp_addr--;
                n_rd++;
            end
            if (dclk_a && !prev_dclk) begin
                r = rises;
                w = 16'hA000 + 16'(15 - r / 16);
                chk({tag, "_di_bit"}, {31'd0, di_a}, {31'd0, w[15 - r % 16]});
                rises++;
            end
            prev_dclk = dclk_a;
            if (lat_a) begin
                if (lat_cyc == 0) lat_first = n;
                lat_cyc++;
                if (!prev_lat) lat_pulses++;
            end
            prev_lat = lat_a;
            if (done_a) begin
                if (done_cnt == 0) done_cyc = n;
                done_cnt++;
            end
        end
        chk({tag, "_rd_count"}, n_rd, 32'd16);
        chk({tag, "_dclk_rises"}, rises, 32'd256);
        chk({tag, "_lat_pulses"}, lat_pulses, 32'd1);
        chk({tag, "_lat_width"}, lat_cyc, 32'd4);
        chk({tag, "_lat_first"}, lat_first, 32'd1057);
        chk({tag, "_done_cycle"}, done_cyc, 32'd1061);
        chk({tag, "_done_count"}, done_cnt, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        int d, n_rd, last_addr, stray, rises_b, err_b, done_b_cyc;
        logic prev_b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_a_outputs", {19'd0, busy_a, done_a, rden_a, addr_a, lat_a, dclk_a, gck_a, di_a}, 32'd0);
        chk("reset_b_outputs", {19'd0, busy_b, done_b, rden_b, addr_b, lat_b, dclk_b, gck_b, di_b}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        gck_mon = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame with a stray frame_start during SHIFT
        run_frame_a("frame1", 100);

        // frame_start held high: next FETCH immediately follows frame_done
        @(negedge clk) fs_a = 1'b1;
        d = 0;
        for (int n = 1; n <= 1200 && d == 0; n++) begin
            @(negedge clk);
            if (done_a) d = n;
        end
        chk("b2b_done_cycle", d, 32'd1061);
        @(negedge clk);
        fs_a = 1'b0;
        chk("b2b_rd_en", {31'd0, rden_a}, 32'd1);
        chk("b2b_rd_addr", {26'd0, addr_a}, 32'd15);
        chk("b2b_busy", {31'd0, busy_a}, 32'd1);

        // Reset during SHIFT of word 7 (relative cycle 560; FETCH of word 7 at 529)
        n_rd = 1;
        last_addr = 15;
        for (int r = 2; r <= 560; r++) begin
            @(negedge clk);
            if (rden_a) begin
                n_rd++;
                last_addr = addr_a;
            end
            if (r == 559) gck_mon = 1'b0;
        end
        chk("abort_words_fetched", n_rd, 32'd9);
        chk("abort_last_addr", last_addr, 32'd7);
        chk("abort_in_shift_busy", {31'd0, busy_a}, 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", {19'd0, busy_a, done_a, rden_a, addr_a, lat_a, dclk_a, gck_a, di_a}, 32'd0);
        rst_a = 1'b0;
        @(negedge clk) chk("gck_restart_0", {31'd0, gck_a}, 32'd0);
        @(negedge clk) chk("gck_restart_1", {31'd0, gck_a}, 32'd1);
        @(negedge clk) chk("gck_restart_2", {31'd0, gck_a}, 32'd1);
        @(negedge clk) chk("gck_restart_3", {31'd0, gck_a}, 32'd0);
        gck_mon = 1'b1;
        stray = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (lat_a || done_a || busy_a || rden_a) stray++;
        end
        chk("abort_no_lat_done", stray, 32'd0);

        // A fresh frame after the abort runs normally from the last word
        run_frame_a("post_abort", 0);
        chk("gck_period_a", gck_err, 32'd0);

        // Instance B: 4 chips, DCLK_DIV=1, all-ones data
        rises_b = 0; err_b = 0; done_b_cyc = 0; prev_b = 1'b0;
        @(negedge clk) fs_b = 1'b1;
        @(posedge clk);
        #1 fs_b = 1'b0;
        for (int n = 1; n <= 2300; n++) begin
            @(negedge clk);
            if (dclk_b && !prev_b) begin
                if (di_b !== 1'b1) err_b++;
                rises_b++;
            end
            prev_b = dclk_b;
            if (done_b && done_b_cyc == 0) done_b_cyc = n;
        end
        chk("b_dclk_rises", rises_b, 32'd1024);
        chk("b_di_all_ones", err_b, 32'd0);
        chk("b_done_cycle", done_b_cyc, 32'd2181);
        chk("b_busy_end", {31'd0, busy_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/my9262_frame_ctrl.md
Name: my9262_frame_ctrl

Overview:
Frame sequencer for a daisy-chained MY9262 LED driver string. On each frame request it fetches every channel's 16-bit grayscale word from an external frame memory and serialises it MSB-first onto my9262_Di/my9262_Dclk. It then pulses my9262_Lat to transfer the data and generates the free-running grayscale clock my9262_Gck. Sits between the frame buffer and the driver pins, in the CLK_200M domain behind the PLL.

Parameters:
CHIPS, 4, number of cascaded MY9262 devices (>=1)
DCLK_DIV, 4, CLK_200M cycles per Dclk half-period (>=1)
GCK_DIV, 2, CLK_200M cycles per Gck half-period (>=1)
LAT_CLKS, 4, Lat high width in CLK_200M cycles (>=1)
ADDR_W, 6, width of rd_addr; must satisfy 2^ADDR_W >= CHIPS*16

Ports:
CLK_200M  in  1  system clock
RST  in  1  synchronous reset, active-high
frame_start  in  1  single-cycle request to send one frame
frame_busy  out  1  high from the cycle after an accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse after Lat falls
rd_en  out  1  frame-memory read strobe
rd_addr  out  ADDR_W  frame-memory word address
rd_data  in  16  grayscale word, valid the cycle after rd_en
my9262_Lat  out  1  latch strobe
my9262_Dclk  out  1  shift clock
my9262_Gck  out  1  grayscale PWM clock
my9262_Di  out  1  serial data

Behaviour:
- Single clock domain. Reset is synchronous, active-high: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; word counter W-1, where W=CHIPS*16.
- States: IDLE, FETCH, LOAD, SHIFT, LATCH, DONE.
- IDLE: on frame_start=1 go to FETCH. frame_start in any other state is ignored (no queuing).
- FETCH (1 cycle): rd_en=1, rd_addr=current word index. Index starts at W-1 and decrements, so the farthest chip's channel 15 goes first.
- LOAD (1 cycle): 16-bit shift register <= rd_data; bit counter <= 15.
- SHIFT: each bit takes 2*DCLK_DIV cycles.
  - Low phase (DCLK_DIV cycles): Dclk=0, Di=shift[15] is stable from the first cycle of the phase.
  - High phase (DCLK_DIV cycles): Dclk=1. The driver samples on the rising edge.
  - At the end of the high phase: shift left by 1 and decrement the bit counter.
  - After bit 0: if the word index is 0, go to LATCH; otherwise decrement the index and go to FETCH.
  - Dclk is held 0 during FETCH/LOAD. Gaps between words are legal.
- LATCH: Dclk=0, Di=0, Lat=1 for exactly LAT_CLKS cycles, then DONE.
- DONE (1 cycle): Lat=0, frame_done=1, then IDLE.
- frame_busy: 1 in FETCH, LOAD, SHIFT, LATCH and DONE.
- Word time: 2+32*DCLK_DIV cycles.
- Timing: with frame_start sampled at cycle 0, frame_done is high at cycle 1 + W*(2+32*DCLK_DIV) + LAT_CLKS.
- Gck: free-running, toggles every GCK_DIV cycles from reset release, independent of state. Not stopped during LATCH.
- Reset mid-frame: immediate abort, all outputs 0 the next cycle, no Lat pulse and no frame_done. Gck restarts from 0.
- frame_start held high continuously: a new frame starts on the cycle after DONE (back-to-back frames).
- Counters are sized from parameters; no wrap occurs within a frame.

Decomposition:
- Package my9262_pkg holds:
  - state enum
  - CH_PER_CHIP=16
  - GS_BITS=16
  - a function for the word count CHIPS*CH_PER_CHIP
- One sub-module, my9262_clk_div: parameterised half-period counter with enable and synchronous clear, producing a toggle output and a phase-end pulse.
  - Instantiated once for Gck (always enabled).
  - Instantiated once for Dclk phase timing (enabled in SHIFT, cleared elsewhere).

Test Plan:
- Single frame, CHIPS=1, DCLK_DIV=2, LAT_CLKS=4, memory word[i]=16'hA000+i; pulse frame_start at cycle 0 -> rd_addr sequence 15..0; 256 Dclk rising edges; bits sampled at rising edges equal A00F..A000 MSB-first; Lat high 4 cycles; frame_done at cycle 1061.
- Gck with GCK_DIV=2 -> period 4 cycles, 50% duty, unchanged across IDLE/SHIFT/LATCH.
- frame_start pulsed again during SHIFT -> ignored; exactly one Lat pulse and one frame_done.
- frame_start held high -> second frame's FETCH occurs the cycle after the first frame_done; rd_addr restarts at W-1.
- RST asserted mid-SHIFT of word 7 -> next cycle all outputs 0, no Lat; a later frame_start gives a full normal frame from rd_addr W-1.
- CHIPS=4, DCLK_DIV=1, all memory words 16'hFFFF -> Di=1 at every one of 1024 rising edges; frame_done at cycle 1+64*34+4=2181.
